// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - parametrised BCD stopwatch/timer counter with lap hold and digit adjust
//
// Even-index digits count mod 10 and odd-index digits count mod 6, so DIGITS=4 is mm:ss.
// Optional blink of the digit under adjust: define STOPWATCH_BLINK_EN.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   tick                one-cycle count strobe
//   btn_reset           clear counter, stop, clear expiry and lap hold
//   btn_pause           toggle run/pause (or acknowledge expiry)
//   btn_lap             toggle lap hold (display frozen, count continues)
//   dir                 0 = count up, 1 = count down
//   adj, sel, num       adjust mode: load num (clamped to digit radix) into digit sel
//   blink_tick          blink strobe for the adjusted digit (optional feature only)
//   digits              packed BCD display value, digit i at [4i+3:4i]
//   blank               per-digit blank mask
//   running, expired    run state, down-count reached zero
//   wrap                one-cycle pulse on up-count rollover
module stopwatch_core #(
    parameter int DIGITS = 4,
    parameter int SELW   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  btn_reset,
    input  logic                  btn_pause,
    input  logic                  btn_lap,
    input  logic                  dir,
    input  logic                  adj,
    input  logic [SELW-1:0]       sel,
    input  logic [3:0]            num,
    input  logic                  blink_tick,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic                  running,
    output logic                  expired,
    output logic                  wrap
);

    localparam int W = 4 * DIGITS;

    function automatic logic [3:0] lim(input int i);
        return (i % 2 == 1) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [W-1:0] max_count();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = lim(i);
        return r;
    endfunction

    localparam logic [W-1:0] MAX_COUNT = max_count();

    // Carry out of the top digit is dropped, so max increments to zero.
    function automatic logic [W-1:0] inc_bcd(input logic [W-1:0] c);
        logic [W-1:0] r;
        logic         carry;
        r     = c;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (c[4*i +: 4] >= lim(i)) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = c[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] c);
        logic [W-1:0] r;
        logic         borrow;
        r      = c;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (c[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = lim(i);
                end else begin
                    r[4*i +: 4] = c[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [W-1:0] count, count_n, lap_reg, lap_reg_n, digits_n;
    logic         lap_hold, lap_hold_n, running_n, expired_n, wrap_n;

    always_comb begin
        count_n    = count;
        lap_reg_n  = lap_reg;
        lap_hold_n = lap_hold;
        running_n  = running;
        expired_n  = expired;
        wrap_n     = 1'b0;
        if (btn_reset) begin
            count_n    = '0;
            running_n  = 1'b0;
            expired_n  = 1'b0;
            lap_hold_n = 1'b0;
        end else if (adj) begin
            running_n  = 1'b0;
            lap_hold_n = 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                if (sel == SELW'(i))
                    count_n[4*i +: 4] = (num > lim(i)) ? lim(i) : num;
            end
        end else begin
            // Lap captures the pre-tick count since it samples the register.
            if (btn_lap) begin
                if (lap_hold) begin
                    lap_hold_n = 1'b0;
                end else begin
                    lap_reg_n  = count;
                    lap_hold_n = 1'b1;
                end
            end
            if (btn_pause) begin
                if (expired)
                    expired_n = 1'b0;
                else if (!running && dir && count == '0)
                    expired_n = 1'b1;
                else
                    running_n = !running;
            end
            // Uses the registered running, so a pause in the same cycle does not eat this tick.
            if (tick && running) begin
                if (!dir) begin
                    count_n = inc_bcd(count);
                    wrap_n  = (count == MAX_COUNT);
                end else begin
                    count_n = (count == '0) ? '0 : dec_bcd(count);
                    if (count_n == '0) begin
                        running_n = 1'b0;
                        expired_n = 1'b1;
                    end
                end
            end
        end
        digits_n = lap_hold_n ? lap_reg_n : count_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            lap_reg  <= '0;
            lap_hold <= 1'b0;
            running  <= 1'b0;
            expired  <= 1'b0;
            wrap     <= 1'b0;
            digits   <= '0;
        end else begin
            count    <= count_n;
            lap_reg  <= lap_reg_n;
            lap_hold <= lap_hold_n;
            running  <= running_n;
            expired  <= expired_n;
            wrap     <= wrap_n;
            digits   <= digits_n;
        end
    end

`ifdef STOPWATCH_BLINK_EN
    logic              blink, blink_n, adj_q;
    logic [DIGITS-1:0] blank_n;

    // adj_q detects the first adjust cycle so blink always starts from the lit phase.
    always_comb begin
        blink_n = 1'b0;
        if (adj && adj_q) blink_n = blink ^ blink_tick;
        blank_n = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj && sel == SELW'(i)) blank_n[i] = blink_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink <= 1'b0;
            adj_q <= 1'b0;
            blank <= '0;
        end else begin
            blink <= blink_n;
            adj_q <= adj;
            blank <= blank_n;
        end
    end
`else
    logic unused_blink_tick;
    assign unused_blink_tick = blink_tick;
    assign blank             = '0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - self-checking bench for stopwatch_core
module tb_stopwatch_core;

    localparam int DIGITS = 4;
    localparam int SELW   = 3;
    localparam int MAXV   = 3599;   // 59:59 in seconds

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                tick = 1'b0, btn_reset = 1'b0, btn_pause = 1'b0, btn_lap = 1'b0;
    logic                dir = 1'b0, adj = 1'b0, blink_tick = 1'b0;
    logic [SELW-1:0]     sel = '0;
    logic [3:0]          num = '0;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   blank;
    logic                running, expired, wrap;

    int vectors = 0;
    int errors  = 0;

    // Reference model: count held as an integer number of seconds.
    int m_val, m_lap;
    bit m_hold, m_run, m_exp, m_wrap, m_blink, m_adjq;

    stopwatch_core #(.DIGITS(DIGITS), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_reset(btn_reset), .btn_pause(btn_pause),
        .btn_lap(btn_lap), .dir(dir), .adj(adj), .sel(sel), .num(num), .blink_tick(blink_tick),
        .digits(digits), .blank(blank), .running(running), .expired(expired), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic int radix(int i);
        return (i % 2 == 1) ? 6 : 10;
    endfunction

    function automatic int weight(int i);
        int w = 1;
        for (int k = 0; k < i; k++) w = w * radix(k);
        return w;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / weight(i)) % radix(i));
        return r;
    endfunction

    function automatic int set_digit(int v, int s, int n);
        int old = (v / weight(s)) % radix(s);
        int nn  = (n > radix(s) - 1) ? radix(s) - 1 : n;
        return v + (nn - old) * weight(s);
    endfunction

    function automatic logic [15:0] exp_digits();
        return m_hold ? to_bcd(m_lap) : to_bcd(m_val);
    endfunction

    function automatic logic [DIGITS-1:0] exp_blank();
        logic [DIGITS-1:0] b = '0;
`ifdef STOPWATCH_BLINK_EN
        if (adj && int'(sel) < DIGITS && m_blink) b[sel] = 1'b1;
`endif
        return b;
    endfunction

    task automatic model_reset();
        m_val = 0; m_lap = 0; m_hold = 0; m_run = 0; m_exp = 0; m_wrap = 0;
        m_blink = 0; m_adjq = 0;
    endtask

    task automatic model_edge();
        bit run0;
        run0   = m_run;
        m_wrap = 0;
        if (!adj || !m_adjq) m_blink = 0;
        else if (blink_tick) m_blink = !m_blink;
        m_adjq = adj;
        if (btn_reset) begin
            m_val = 0; m_run = 0; m_exp = 0; m_hold = 0;
        end else if (adj) begin
            m_run = 0; m_hold = 0;
            if (int'(sel) < DIGITS) m_val = set_digit(m_val, int'(sel), int'(num));
        end else begin
            if (btn_lap) begin
                if (m_hold) m_hold = 0;
                else begin m_lap = m_val; m_hold = 1; end
            end
            if (btn_pause) begin
                if (m_exp) m_exp = 0;
                else if (!m_run && dir && m_val == 0) m_exp = 1;
                else m_run = !m_run;
            end
            if (tick && run0) begin
                if (!dir) begin
                    m_wrap = (m_val == MAXV);
                    m_val  = (m_val + 1) % (MAXV + 1);
                end else begin
                    if (m_val > 0) m_val = m_val - 1;
                    if (m_val == 0) begin m_run = 0; m_exp = 1; end
                end
            end
        end
    endtask

    // One clock edge: advance model, wait for edge, drop one-cycle pulses.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        tick = 0; btn_reset = 0; btn_pause = 0; btn_lap = 0; blink_tick = 0;
    endtask

    task automatic load_value(input logic [15:0] bcd);
        adj = 1;
        for (int i = 0; i < DIGITS; i++) begin
            sel = SELW'(i);
            num = bcd[4*i +: 4];
            step();
        end
        adj = 0;
        step();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        #2;
        model_reset();
        vectors++;
        if (digits !== 16'h0000 || running !== 1'b0 || expired !== 1'b0 || wrap !== 1'b0 || blank !== 4'h0) begin
            errors++;
            $display("FAIL reset: digits=%h run=%b exp=%b wrap=%b blank=%b required 0000/0/0/0/0",
                     digits, running, expired, wrap, blank);
        end
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_up_count();
        dir = 0; btn_pause = 1; step();
        for (int i = 0; i < 60; i++) begin tick = 1; step(); end
        vectors++;
        if (digits !== 16'h0100 || running !== 1'b1) begin
            errors++;
            $display("FAIL up_count: digits=%h run=%b required 0100/1", digits, running);
        end
    endtask

    task automatic test_rollover();
        load_value(16'h5959);
        btn_pause = 1; step();
        tick = 1; step();
        vectors++;
        if (digits !== 16'h0000 || wrap !== 1'b1 || running !== 1'b1) begin
            errors++;
            $display("FAIL rollover: digits=%h wrap=%b run=%b required 0000/1/1", digits, wrap, running);
        end
        step();
        vectors++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pulse: wrap=%b required 0", wrap);
        end
    endtask

    task automatic test_down_expiry();
        btn_reset = 1; step();
        load_value(16'h0002);
        dir = 1; btn_pause = 1; step();
        tick = 1; step();
        tick = 1; step();
        vectors++;
        if (digits !== 16'h0000 || expired !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL down_expiry: digits=%h exp=%b run=%b required 0000/1/0", digits, expired, running);
        end
        tick = 1; step();
        vectors++;
        if (digits !== 16'h0000 || expired !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL down_hold: digits=%h exp=%b run=%b required 0000/1/0", digits, expired, running);
        end
        btn_pause = 1; step();
        vectors++;
        if (expired !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL expiry_ack: exp=%b run=%b required 0/0", expired, running);
        end
        btn_pause = 1; step();
        step();
        vectors++;
        if (expired !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL start_at_zero: exp=%b run=%b required 1/0", expired, running);
        end
        btn_pause = 1; step();
        dir = 0;
    endtask

    task automatic test_adjust();
        btn_reset = 1; step();
        adj = 1; sel = 1; num = 9; step();
        vectors++;
        if (digits !== 16'h0050) begin
            errors++;
            $display("FAIL adjust_clamp: digits=%h required 0050", digits);
        end
        sel = 5; num = 3; step();
        tick = 1; btn_pause = 1; step();
        vectors++;
        if (digits !== 16'h0050 || running !== 1'b0) begin
            errors++;
            $display("FAIL adjust_ignore: digits=%h run=%b required 0050/0", digits, running);
        end
        adj = 0; step();
    endtask

    task automatic test_lap();
        btn_reset = 1; step();
        load_value(16'h0012);
        dir = 0; btn_pause = 1; step();
        btn_lap = 1; step();
        for (int i = 0; i < 3; i++) begin tick = 1; step(); end
        vectors++;
        if (digits !== 16'h0012) begin
            errors++;
            $display("FAIL lap_hold: digits=%h required 0012", digits);
        end
        btn_lap = 1; step();
        vectors++;
        if (digits !== 16'h0015) begin
            errors++;
            $display("FAIL lap_release: digits=%h required 0015", digits);
        end
        for (int i = 0; i < 5; i++) begin tick = 1; step(); end
        btn_lap = 1; tick = 1; step();
        tick = 1; step();
        vectors++;
        if (digits !== 16'h0020) begin
            errors++;
            $display("FAIL lap_with_tick: digits=%h required 0020", digits);
        end
        btn_lap = 1; step();
        vectors++;
        if (digits !== 16'h0022) begin
            errors++;
            $display("FAIL lap_underneath: digits=%h required 0022", digits);
        end
    endtask

    task automatic test_blink();
        logic [3:0] want [3];
`ifdef STOPWATCH_BLINK_EN
        want[0] = 4'b0100; want[1] = 4'b0000; want[2] = 4'b0100;
`else
        want[0] = 4'b0000; want[1] = 4'b0000; want[2] = 4'b0000;
`endif
        adj = 1; sel = 2; num = 0; step();
        for (int i = 0; i < 3; i++) begin
            blink_tick = 1; step();
            vectors++;
            if (blank !== want[i]) begin
                errors++;
                $display("FAIL blink_%0d: blank=%b required %b", i, blank, want[i]);
            end
        end
        adj = 0; step();
        vectors++;
        if (blank !== 4'b0000) begin
            errors++;
            $display("FAIL blink_exit: blank=%b required 0000", blank);
        end
    endtask

    task automatic test_async_reset_midrun();
        load_value(16'h0345);
        btn_pause = 1; step();
        tick = 1; step();
        #2;
        rst = 1;
        #1;
        model_reset();
        vectors++;
        if (digits !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: digits=%h run=%b required 0000/0", digits, running);
        end
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            tick       = ($urandom_range(0, 99) < 50);
            btn_pause  = ($urandom_range(0, 99) < 6);
            btn_lap    = ($urandom_range(0, 99) < 5);
            btn_reset  = ($urandom_range(0, 999) < 5);
            blink_tick = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 4) adj = !adj;
            if ($urandom_range(0, 99) < 3) dir = !dir;
            sel = SELW'($urandom_range(0, 7));
            num = 4'($urandom_range(0, 15));
            step();
            vectors++;
            if (digits !== exp_digits() || running !== m_run || expired !== m_exp ||
                wrap !== m_wrap || blank !== exp_blank()) begin
                errors++;
                $display("FAIL random_%0d: digits=%h run=%b exp=%b wrap=%b blank=%b required %h/%b/%b/%b/%b",
                         n, digits, running, expired, wrap, blank,
                         exp_digits(), m_run, m_exp, m_wrap, exp_blank());
            end
        end
        adj = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_up_count();
        test_rollover();
        test_down_expiry();
        test_adjust();
        test_lap();
        test_blink();
        test_async_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Parametrised BCD stopwatch/timer counter; successor to the fixed mm:ss counter.
- Generalised digit count, up/down direction, expiry, lap hold and per-digit adjust.
- Sits between clkdiv/debounce (consumes 1 Hz strobe and debounced pulses) and display (drives packed BCD digits).

Parameters:
- DIGITS, 4, number of BCD digits, even, 2..8; digit 0 = LSB.
- SELW, 3, width of sel; must satisfy 2^SELW >= DIGITS.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle count strobe (1 Hz from clkdiv).
- btn_reset  input  1  one-cycle debounced pulse; clears the counter.
- btn_pause  input  1  one-cycle debounced pulse; toggles run/pause.
- btn_lap  input  1  one-cycle pulse; toggles lap hold.
- dir  input  1  0 = count up, 1 = count down.
- adj  input  1  adjust mode.
- sel  input  SELW  digit index to adjust.
- num  input  4  BCD value to load in adjust mode.
- blink_tick  input  1  blink strobe (used only with the optional feature).
- digits  output  4*DIGITS  displayed BCD value; digit i at [4i+3:4i].
- blank  output  DIGITS  per-digit blank mask for display.
- running  output  1  counter is running.
- expired  output  1  down-count reached zero.
- wrap  output  1  one-cycle pulse on up-count rollover.

Behaviour:
- Radix: even-index digits are mod 10; odd-index digits are mod 6 (mm:ss, hh:mm:ss ...). Maximum count is 5959 for DIGITS=4.
- All outputs are registered. On rst: count=0, lap_reg=0, lap_hold=0, running=0, expired=0, wrap=0, blank=0, digits=0.
- Priority per edge: rst > btn_reset > adj > btn_pause/btn_lap/tick.
- btn_reset: count=0, running=0, expired=0, lap_hold=0. Takes effect regardless of adj.
- Adjust (adj=1):
  - running forced to 0.
  - Each cycle, digit[sel] <= min(num, radix(sel)-1).
  - sel >= DIGITS: no change.
  - tick, btn_pause and btn_lap are ignored.
  - lap_hold is forced to 0.
  - Leaving adj leaves running=0.
- btn_pause (adj=0):
  - If expired=1: clear expired, running stays 0.
  - Otherwise toggle running.
  - Starting a down-count at count=0 sets expired=1 next edge; running stays 0.
- Tick (tick=1, running=1, adj=0) uses running as registered before the edge. A btn_pause in the same cycle still lets that tick count.
- Up count:
  - Ripple-carry increment.
  - At max, wrap to 0 and pulse wrap=1 for one cycle; running stays 1.
- Down count:
  - Ripple-borrow decrement.
  - When the result is 0: running<=0 and expired<=1 on the same edge. count stays at 0.
- dir change mid-run applies from the next tick. expired is never set in up mode.
- Lap (adj=0):
  - btn_lap with lap_hold=0: lap_reg<=count, lap_hold<=1.
  - btn_lap with lap_hold=1: lap_hold<=0.
  - Count continues underneath.
  - digits = lap_hold ? lap_reg : count.
  - btn_lap coinciding with a tick captures the pre-tick count.
- Latency: count change is visible on digits one cycle after the tick cycle.
- Reset mid-run clears everything asynchronously, with no partial-carry state.

Optional Feature:
- Macro STOPWATCH_BLINK_EN.
- Defined:
  - In adj mode, a blink register toggles on each blink_tick.
  - blank[sel] = blink, and all other bits are 0.
  - blink clears on entering adj and on rst.
  - When adj=0, blank=0.
- Undefined: blank is tied to 0, blink_tick is ignored, and no blink register exists.

Test Plan:
- Up count: rst, dir=0, btn_pause, 60 ticks -> digits=0x0100, running=1.
- Rollover: adjust to 5959, leave adj, btn_pause, 1 tick -> digits=0x0000, wrap high exactly 1 cycle, running=1.
- Down count to expiry: adjust to 0002, dir=1, btn_pause, 2 ticks -> digits=0x0000, expired=1, running=0. 3rd tick -> no change. btn_pause -> expired=0, running=0.
- Adjust clamp: adj=1, sel=1, num=9 -> digit1=5. sel=5, num=3 -> no change. tick during adj -> no count.
- Lap: running up at 0012, btn_lap -> digits hold 0x0012 while 3 more ticks pass. btn_lap again -> digits=0x0015. btn_lap and tick in the same cycle at 0020 -> lap shows 0x0020.
- Blink (STOPWATCH_BLINK_EN): adj=1, sel=2, 3 blink_ticks -> blank toggles 0100/0000/0100. adj=0 -> blank=0000.
